store_aligner: RTL

//  Write-side counterpart of the load-data aligner. It takes store requests from the MEM stage:

---
 rtl/store_aligner.sv | 243 ++++++++++++++++++++++++
 1 files changed

// File: rtl/store_aligner.sv
// store_aligner
//   Write-side aligner for the MEM stage. Byte/half/word stores with a byte
//   address are turned into word-aligned write beats with byte strobes. A
//   DEPTH-entry queue decouples the pipeline from memory backpressure, and a
//   store that crosses a word boundary leaves as two adjacent beats.
//
// Ports
//   CLK, RSTN              clock, asynchronous active-low reset
//   ST_VALID / ST_READY    store handshake (ST_READY = queue not full)
//   ST_ADDR, ST_DATA       byte address, right-justified store data
//   ST_FUNCT3              000=SB, 001=SH, 010=SW, anything else is illegal
//   MEM_VALID / MEM_READY  write beat handshake
//   MEM_ADDR               word address of the beat ([1:0] always 00)
//   MEM_WDATA, MEM_WSTRB   lane-positioned data and byte strobes
//   BUSY                   queue non-empty or beat on the memory port
//   ERR                    one-cycle pulse after an accepted illegal funct3
//
// Issue FSM
//   state | meaning
//   IDLE  | no beat presented, MEM_* held at zero
//   B0    | presenting beat0 of the queue head
//   B1    | presenting beat1 of a split queue head
module store_aligner #(
    parameter int DEPTH = 4
) (
    input  logic        CLK,
    input  logic        RSTN,
    input  logic        ST_VALID,
    output logic        ST_READY,
    input  logic [31:0] ST_ADDR,
    input  logic [31:0] ST_DATA,
    input  logic [2:0]  ST_FUNCT3,
    output logic        MEM_VALID,
    input  logic        MEM_READY,
    output logic [31:0] MEM_ADDR,
    output logic [31:0] MEM_WDATA,
    output logic [3:0]  MEM_WSTRB,
    output logic        BUSY,
    output logic        ERR
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_B0   = 2'd1,
        S_B1   = 2'd2
    } state_t;

    // Queue storage: word address of beat0 plus the full 8-lane view of the
    // store, so beat1 is simply the upper half.
    logic [29:0] q_word [DEPTH];
    logic [63:0] q_data [DEPTH];
    logic [7:0]  q_strb [DEPTH];

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] rd_ptr_nx1;
    logic [CW-1:0] count;
    logic          full;

    logic          legal;
    logic [3:0]    mask4;
    logic [31:0]   data_m;
    logic [1:0]    off;
    logic [7:0]    wstrb8;
    logic [63:0]   wdata64;
    logic          accept;
    logic          push;
    logic          pop;
    logic          advance;

    state_t        state;
    state_t        state_nx;
    logic          mem_valid_q;
    logic [31:0]   mem_addr_q;
    logic [31:0]   mem_wdata_q;
    logic [3:0]    mem_wstrb_q;
    logic          valid_nx;
    logic [31:0]   addr_nx;
    logic [31:0]   wdata_nx;
    logic [3:0]    wstrb_nx;
    logic          err_q;

    logic          head_has_b1;

    // ------------------------------------------------------------------
    // Enqueue side
    // ------------------------------------------------------------------
    assign full     = (count == CW'(DEPTH));
    assign ST_READY = !full;
    assign accept   = ST_VALID && ST_READY;
    assign off      = ST_ADDR[1:0];

    always_comb begin
        legal  = 1'b1;
        mask4  = 4'b0000;
        data_m = 32'h0;
        case (ST_FUNCT3)
            3'b000: begin
                mask4  = 4'b0001;
                data_m = {24'h0, ST_DATA[7:0]};
            end
            3'b001: begin
                mask4  = 4'b0011;
                data_m = {16'h0, ST_DATA[15:0]};
            end
            3'b010: begin
                mask4  = 4'b1111;
                data_m = ST_DATA;
            end
            default: legal = 1'b0;
        endcase
    end

    // Unused byte lanes are zeroed so the upper half of wdata64 carries only
    // the bytes that spill into the next word.
    assign wstrb8  = {4'b0000, mask4} << off;
    assign wdata64 = {32'h0, data_m} << {off, 3'b000};
    assign push    = accept && legal;

    always_ff @(posedge CLK) begin
        if (push) begin
            q_word[wr_ptr] <= ST_ADDR[31:2];
            q_data[wr_ptr] <= wdata64;
            q_strb[wr_ptr] <= wstrb8;
        end
    end

    assign rd_ptr_nx1  = rd_ptr + 1'b1;
    assign head_has_b1 = (q_strb[rd_ptr][7:4] != 4'b0000);

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            err_q  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr_nx1;
            end
            count <= count + CW'(push) - CW'(pop);
            err_q <= accept && !legal;
        end
    end

    // ------------------------------------------------------------------
    // Issue FSM
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state       <= S_IDLE;
            mem_valid_q <= 1'b0;
            mem_addr_q  <= 32'h0;
            mem_wdata_q <= 32'h0;
            mem_wstrb_q <= 4'b0000;
        end else begin
            state       <= state_nx;
            mem_valid_q <= valid_nx;
            mem_addr_q  <= addr_nx;
            mem_wdata_q <= wdata_nx;
            mem_wstrb_q <= wstrb_nx;
        end
    end

    always_comb begin
        state_nx = state;
        valid_nx = mem_valid_q;
        addr_nx  = mem_addr_q;
        wdata_nx = mem_wdata_q;
        wstrb_nx = mem_wstrb_q;
        advance  = 1'b0;
        pop      = 1'b0;

        case (state)
            S_IDLE: begin
                if (count != '0) begin
                    state_nx = S_B0;
                    valid_nx = 1'b1;
                    addr_nx  = {q_word[rd_ptr], 2'b00};
                    wdata_nx = q_data[rd_ptr][31:0];
                    wstrb_nx = q_strb[rd_ptr][3:0];
                end
            end
            S_B0: begin
                if (MEM_READY) begin
                    if (head_has_b1) begin
                        state_nx = S_B1;
                        addr_nx  = {q_word[rd_ptr] + 30'd1, 2'b00};
                        wdata_nx = q_data[rd_ptr][63:32];
                        wstrb_nx = q_strb[rd_ptr][7:4];
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            S_B1: begin
                if (MEM_READY) begin
                    advance = 1'b1;
                end
            end
            default: begin
                state_nx = S_IDLE;
                valid_nx = 1'b0;
                addr_nx  = 32'h0;
                wdata_nx = 32'h0;
                wstrb_nx = 4'b0000;
            end
        endcase

        // Head retires; the next entry is read straight from the queue so
        // consecutive entries go out without a bubble.
        if (advance) begin
            pop = 1'b1;
            if (count > CW'(1)) begin
                state_nx = S_B0;
                valid_nx = 1'b1;
                addr_nx  = {q_word[rd_ptr_nx1], 2'b00};
                wdata_nx = q_data[rd_ptr_nx1][31:0];
                wstrb_nx = q_strb[rd_ptr_nx1][3:0];
            end else begin
                state_nx = S_IDLE;
                valid_nx = 1'b0;
                addr_nx  = 32'h0;
                wdata_nx = 32'h0;
                wstrb_nx = 4'b0000;
            end
        end
    end

    assign MEM_VALID = mem_valid_q;
    assign MEM_ADDR  = mem_addr_q;
    assign MEM_WDATA = mem_wdata_q;
    assign MEM_WSTRB = mem_wstrb_q;
    assign BUSY      = (count != '0) || mem_valid_q;
    assign ERR       = err_q;

endmodule
